spram_ctrl: RTL and testbench

//  Initiator-side controller for the single-port block RAM wrapper (en/wnr/addr/wdata in, rdata 1 cycle later).

---
 rtl/spram_ctrl.sv | 155 +++++++++++++++
 tb/tb_spram_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_ctrl.sv
// spram_ctrl: initiator-side controller for a single-port block RAM.
// Converts a valid/ready request stream into RAM accesses. Read data returns
// through a 2-entry response buffer with valid/ready back-pressure. An optional
// zero-fill sweep runs over the whole RAM after reset.
module spram_ctrl #(
    parameter int A   = 6,
    parameter int D   = 32,
    parameter bit CLR = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_wnr,
    input  logic [A-1:0] req_addr,
    input  logic [D-1:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [D-1:0] resp_rdata,
    output logic         busy,
    output logic         mem_en,
    output logic         mem_wnr,
    output logic [A-1:0] mem_addr,
    output logic [D-1:0] mem_wdata,
    input  logic [D-1:0] mem_rdata
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [A-1:0] CNT_ONE  = {{(A-1){1'b0}}, 1'b1};
    localparam logic [A-1:0] CNT_LAST = {A{1'b1}};

    state_t       state;
    logic [A-1:0] clr_cnt;
    logic         busy_q;

    // A read was issued last cycle; mem_rdata is meaningful this cycle only.
    logic         inflight;

    // Response buffer: two entries, head pointer, tail pointer, occupancy.
    logic [D-1:0] buf_q [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;

    logic         in_run;
    logic         in_init;
    logic         push;
    logic         pop;
    logic [2:0]   used;
    logic         credit_ok;
    logic         accept;
    logic         rd_accept;

    // Gating with rst keeps every output quiet while reset is held, even
    // though the state register already holds its post-reset value.
    assign in_run  = rst && (state == ST_RUN);
    assign in_init = rst && (state == ST_INIT);

    assign resp_valid = (count != 2'd0);
    assign resp_rdata = buf_q[rd_ptr];
    assign pop        = resp_valid && resp_ready;
    assign push       = inflight;

    // Read slots committed after this cycle's pop. Two slots exist (one read in
    // the RAM pipe, buffer entries), so a new read needs fewer than two in use.
    // pop can only be high when count >= 1, so this never underflows.
    assign used      = {2'b00, inflight} + {1'b0, count} - {2'b00, pop};
    assign credit_ok = (used < 3'd2);

    // Writes never produce a response, so they bypass the credit check.
    assign req_ready = in_run && (req_wnr || credit_ok);
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_wnr;

    assign busy = busy_q;

    // RAM port mux: the sweep owns the port in INIT; accepted requests pass
    // through in RUN; otherwise every RAM input is held at zero.
    always_comb begin
        mem_en    = 1'b0;
        mem_wnr   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (in_init) begin
            mem_en   = 1'b1;
            mem_wnr  = 1'b1;
            mem_addr = clr_cnt;
        end else if (accept) begin
            mem_en    = 1'b1;
            mem_wnr   = req_wnr;
            mem_addr  = req_addr;
            mem_wdata = req_wdata;
        end
    end

    // Control FSM: zero-fill sweep over every address, then RUN until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLR ? ST_INIT : ST_RUN;
            clr_cnt <= '0;
            busy_q  <= CLR;
        end else begin
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + CNT_ONE;
                    if (clr_cnt == CNT_LAST) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Track the read sitting in the RAM pipeline so its data is captured next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_accept;
        end
    end

    // Response buffer: capture RAM data one cycle after a read, release on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr] <= mem_rdata;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_ctrl.sv
// Testbench for spram_ctrl: a zero-fill instance (A=4) driven by tables, directed
// sequences and random traffic against a transaction-level model, plus a
// no-clear instance backed by a fixed-content RAM.
module tb_spram_ctrl;

    localparam int A     = 4;
    localparam int D     = 32;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst;

    logic         req_valid, req_ready, req_wnr;
    logic [A-1:0] req_addr;
    logic [D-1:0] req_wdata;
    logic         resp_valid, resp_ready;
    logic [D-1:0] resp_rdata;
    logic         busy, mem_en, mem_wnr;
    logic [A-1:0] mem_addr;
    logic [D-1:0] mem_wdata, mem_rdata;

    logic         z_req_valid, z_req_ready, z_req_wnr;
    logic [A-1:0] z_req_addr;
    logic [D-1:0] z_req_wdata;
    logic         z_resp_valid, z_resp_ready;
    logic [D-1:0] z_resp_rdata;
    logic         z_busy, z_mem_en, z_mem_wnr;
    logic [A-1:0] z_mem_addr;
    logic [D-1:0] z_mem_wdata, z_mem_rdata;

    always #5 clk = ~clk;

    spram_ctrl #(.A(A), .D(D), .CLR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wnr(req_wnr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .busy(busy), .mem_en(mem_en), .mem_wnr(mem_wnr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    spram_ctrl #(.A(A), .D(D), .CLR(1'b0)) dut_noclr (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_wnr(z_req_wnr),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata),
        .busy(z_busy), .mem_en(z_mem_en), .mem_wnr(z_mem_wnr), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
    );

    // Read-first single-port RAM with garbage initial content.
    logic [D-1:0] ram [DEPTH];
    bit           ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
            ram_loaded = 1'b1;
        end
        if (mem_en) begin
            if (mem_wnr) ram[mem_addr] = mem_wdata;
            else         mem_rdata <= ram[mem_addr];
        end
    end

    // Fixed-content RAM for the no-clear instance: address i holds 0xA5000000+i.
    always @(posedge clk) begin
        if (z_mem_en && !z_mem_wnr) z_mem_rdata <= 32'hA500_0000 | 32'(z_mem_addr);
    end

    // Transaction-level model state.
    typedef struct {
        logic [D-1:0] data;
        int           vis;
    } resp_t;

    typedef struct {
        bit           wnr;
        logic [A-1:0] addr;
        logic [D-1:0] wdata;
        logic [D-1:0] exp;
    } vec_t;

    resp_t        q[$];
    logic [D-1:0] shadow [DEPTH];
    logic [D-1:0] got[$];
    logic [D-1:0] exp_q[$];
    int           sweep_left = 0;
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;
    bit           last_acc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare one cycle of DUT behaviour with the model, then advance the model.
    task automatic check_cycle();
        logic exp_busy, exp_valid, exp_ready, exp_en;
        int   outstanding;
        exp_busy  = (sweep_left > 0);
        exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
        exp_ready = 1'b0;
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("resp_valid", 64'(resp_valid), 64'(exp_valid));
        if (exp_valid) chk("resp_rdata", 64'(resp_rdata), 64'(q[0].data));
        if (exp_busy) begin
            chk("sweep_port", 64'({mem_en, mem_wnr, mem_addr, mem_wdata}),
                64'({1'b1, 1'b1, 4'(DEPTH - sweep_left), 32'h0}));
        end else begin
            outstanding = q.size() - ((exp_valid && resp_ready) ? 1 : 0);
            exp_ready   = req_wnr || (outstanding < 2);
            exp_en      = req_valid && exp_ready;
            chk("mem_port", 64'({mem_en, mem_wnr, mem_addr, mem_wdata}),
                64'(exp_en ? {1'b1, req_wnr, req_addr, req_wdata} : 38'h0));
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));

        if (exp_valid && resp_ready) begin
            got.push_back(resp_rdata);
            if (exp_q.size() > 0) begin
                chk("table_rdata", 64'(resp_rdata), 64'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            void'(q.pop_front());
        end
        last_acc = req_valid && req_ready;
        if (last_acc) begin
            if (req_wnr) shadow[req_addr] = req_wdata;
            else         q.push_back('{data: shadow[req_addr], vis: cyc + 2});
        end
    endtask

    // Called at posedge+1 with inputs already set; returns at the next posedge+1.
    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        cyc++;
        if (sweep_left > 0) sweep_left--;
        #1;
    endtask

    task automatic wait_accept(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 40);
        if (!last_acc) begin
            checks++;
            errors++;
            $display("FAIL %s: request not accepted within %0d cycles", name, n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        while (q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_mem_port"}, 64'({mem_en, mem_wnr, mem_addr, mem_wdata}), 64'd0);
        chk({tag, "_z_busy"}, 64'(z_busy), 64'd0);
        chk({tag, "_z_req_ready"}, 64'(z_req_ready), 64'd0);
        chk({tag, "_z_mem_en"}, 64'(z_mem_en), 64'd0);
    endtask

    task automatic clear_model();
        q.delete();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    endtask

    task automatic check_got(input string name);
        chk({name, "_count"}, 64'(got.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) chk({name, "_data"}, 64'(got[i]), 64'(32'h100 + i));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [9];
        int   n;
        int   k;

        vecs[0] = '{1'b1, 4'd5,  32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 4'd5,  32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 4'd6,  32'h0,         32'h0};
        vecs[3] = '{1'b1, 4'd0,  32'h1111_1111, 32'h0};
        vecs[4] = '{1'b1, 4'd0,  32'h2222_2222, 32'h0};
        vecs[5] = '{1'b0, 4'd0,  32'h0,         32'h2222_2222};
        vecs[6] = '{1'b1, 4'd15, 32'hCAFE_F00D, 32'h0};
        vecs[7] = '{1'b0, 4'd15, 32'h0,         32'hCAFE_F00D};
        vecs[8] = '{1'b0, 4'd5,  32'h0,         32'hDEAD_BEEF};

        rst = 1'b0;
        req_valid = 1'b0; req_wnr = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_wnr = 1'b0; z_req_addr = '0; z_req_wdata = '0;
        z_resp_ready = 1'b1;
        clear_model();

        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");

        // Requests presented before and during the sweep must wait, not vanish.
        req_valid = 1'b1; req_wnr = 1'b0; req_addr = 4'd9;
        exp_q.push_back(32'h0);
        z_req_valid = 1'b1; z_req_wnr = 1'b0; z_req_addr = 4'd3;

        rst = 1'b1;
        sweep_left = DEPTH;
        #1;
        chk("z_ready_first", 64'(z_req_ready), 64'd1);
        chk("z_busy_run", 64'(z_busy), 64'd0);
        tick();
        n = 1;
        z_req_valid = 1'b0;
        chk("z_resp_early", 64'(z_resp_valid), 64'd0);
        tick();
        n = 2;
        chk("z_resp_valid", 64'(z_resp_valid), 64'd1);
        chk("z_resp_rdata", 64'(z_resp_rdata), 64'(32'hA500_0003));
        while (!last_acc && n < 40) begin
            tick();
            n++;
        end
        chk("held_read_wait", 64'(n), 64'd17);
        req_valid = 1'b0;
        drain();
        chk("held_read_resp", 64'(exp_q.size()), 64'd0);

        // Table: write/read pairs issued back to back.
        resp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            req_valid = 1'b1;
            req_wnr   = vecs[i].wnr;
            req_addr  = vecs[i].addr;
            req_wdata = vecs[i].wdata;
            if (!vecs[i].wnr) exp_q.push_back(vecs[i].exp);
            wait_accept("table_accept");
        end
        drain();
        chk("table_all_resp", 64'(exp_q.size()), 64'd0);

        // Preload 0x100+i at addresses 0..7.
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_wnr = 1'b1; req_addr = 4'(i); req_wdata = 32'h100 + i;
            wait_accept("preload");
        end

        // Back-to-back reads with the consumer always ready.
        got.delete();
        req_wnr = 1'b0; resp_ready = 1'b1;
        n = 0; k = 0;
        while (k < 8 && n < 40) begin
            req_valid = 1'b1;
            req_addr  = 4'(k);
            tick();
            n++;
            if (last_acc) k++;
        end
        req_valid = 1'b0;
        chk("b2b_cycles", 64'(n), 64'd8);
        drain();
        check_got("b2b");

        // Same reads with the consumer stalled: only two read credits exist.
        got.delete();
        resp_ready = 1'b0; req_wnr = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1;
            req_addr  = 4'(k);
            tick();
            if (last_acc) k++;
        end
        chk("stall_reads_accepted", 64'(k), 64'd2);
        chk("stall_resp_valid", 64'(resp_valid), 64'd1);
        req_wnr = 1'b1; req_addr = 4'd12; req_wdata = 32'h5A5A_5A5A;
        tick();
        chk("stall_write_accepted", 64'(last_acc), 64'd1);
        req_wnr = 1'b0; resp_ready = 1'b1;
        n = 0;
        while (k < 8 && n < 40) begin
            req_addr = 4'(k);
            tick();
            n++;
            if (last_acc) k++;
        end
        drain();
        check_got("stall");

        // Random traffic against the model.
        for (int c = 0; c < 300; c++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_wnr    = ($urandom_range(0, 2) == 0);
            req_addr   = 4'($urandom_range(0, DEPTH - 1));
            req_wdata  = $urandom;
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset with two responses buffered, then reset again mid-sweep.
        resp_ready = 1'b0; req_wnr = 1'b0; req_addr = 4'd3;
        n = 0; k = 0;
        while (k < 2 && n < 10) begin
            req_valid = 1'b1;
            tick();
            n++;
            if (last_acc) k++;
        end
        req_valid = 1'b0;
        tick();
        tick();
        chk("pre_reset_resp_valid", 64'(resp_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk_reset("run_rst");
        clear_model();
        sweep_left = 0;
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b1;
        sweep_left = DEPTH;
        repeat (9) tick();
        rst = 1'b0;
        #1;
        chk_reset("sweep_rst");
        sweep_left = 0;
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b1;
        sweep_left = DEPTH;
        repeat (DEPTH) tick();
        chk("resweep_done", 64'(busy), 64'd0);

        // Post-sweep traffic: unwritten locations must read back as zero.
        for (int c = 0; c < 150; c++) begin
            req_valid  = ($urandom_range(0, 1) != 0);
            req_wnr    = ($urandom_range(0, 3) == 0);
            req_addr   = 4'($urandom_range(0, DEPTH - 1));
            req_wdata  = $urandom;
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
